// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle RV32I control FSM: opcodes, states, datapath mux selects
// and trap causes.
package mc_ctrl_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_OP     = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_TRAP,
        S_HALT
    } state_e;

    typedef enum logic {
        ADDR_PC_OUT  = 1'b0,
        ADDR_ALU_OUT = 1'b1
    } addrSrc_e;

    typedef enum logic [1:0] {
        REG_PC  = 2'd0,
        REG_ALU = 2'd1,
        REG_MEM = 2'd2
    } regSrc_e;

    typedef enum logic [1:0] {
        A_CURR_PC = 2'd0,
        A_OLD_PC  = 2'd1,
        A_RS1     = 2'd2,
        A_ZERO    = 2'd3
    } aluSrcA_e;

    typedef enum logic [1:0] {
        B_RS2   = 2'd0,
        B_IMMED = 2'd1,
        B_FOUR  = 2'd2
    } aluSrcB_e;

    typedef enum logic {
        ADD_OP = 1'b0,
        ALU_OP = 1'b1
    } aluCtrl_e;

    typedef enum logic [1:0] {
        CAUSE_NONE        = 2'd0,
        CAUSE_ILLEGAL     = 2'd1,
        CAUSE_ECALL       = 2'd2,
        CAUSE_BUS_TIMEOUT = 2'd3
    } cause_e;

    // ECALL/EBREAK share funct3 000; every other SYSTEM funct3 (CSR ops) is treated as illegal.
    localparam logic [2:0] F3_PRIV = 3'b000;

endpackage

// File: rtl/mc_timeout_ctr.sv
// Wait-state counter for the memory handshake: o_expire is high once MEM_TIMEOUT-1 unacked
// cycles have been counted since the last clear.
module mc_timeout_ctr #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expire = (r_count == LAST);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM with req/ack memory handshake, bus timeout, trap causes and instret.
// Build option: define CTRL_TRAP_EN to route faults through a 1-cycle TRAP state instead of HALT.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic             i_error,
    input  logic             i_mem_ack,
    output logic             o_mem_req,
    output logic             o_enBranch,
    output logic             o_pcUpdate,
    output logic             o_irWrite,
    output logic             o_addrSrc,
    output logic             o_memWrite,
    output logic             o_memRead,
    output logic [1:0]       o_regSrc,
    output logic             o_regWrite,
    output logic [1:0]       o_aluSrcA,
    output logic [1:0]       o_aluSrcB,
    output logic             o_aluCtrl,
    output logic             o_trap_taken,
    output logic [1:0]       o_trap_cause,
    output logic             o_halted,
    output logic             o_retire,
    output logic [CNT_W-1:0] o_instret
);

`ifdef CTRL_TRAP_EN
    localparam state_e S_FAULT = S_TRAP;
`else
    localparam state_e S_FAULT = S_HALT;
`endif

    state_e           r_state;
    cause_e           r_cause;
    logic [CNT_W-1:0] r_instret;

    logic w_waiting;
    logic w_expire;
    logic w_isLoad;
    logic w_retire;

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_isLoad  = (i_opcode == OP_LOAD);

    mc_timeout_ctr #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (!w_waiting || i_mem_ack),
        .i_enable(w_waiting && !i_mem_ack),
        .o_expire(w_expire)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_FETCH;
            r_cause   <= CAUSE_NONE;
            r_instret <= '0;
        end else begin
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (i_error) begin
                r_state <= S_HALT;
            end else begin
                case (r_state)
                    S_FETCH: begin
                        if (i_mem_ack) begin
                            r_state <= S_DECODE;
                        end else if (w_expire) begin
                            r_state <= S_FAULT;
                            r_cause <= CAUSE_BUS_TIMEOUT;
                        end
                    end
                    S_DECODE: r_state <= S_EXECUTE;
                    S_EXECUTE: begin
                        case (i_opcode)
                            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_IMM, OP_OP:
                                r_state <= S_FETCH;
                            OP_LOAD, OP_STORE:
                                r_state <= S_MEM;
                            OP_SYSTEM: begin
                                r_state <= S_FAULT;
                                r_cause <= (i_funct3 == F3_PRIV) ? CAUSE_ECALL : CAUSE_ILLEGAL;
                            end
                            default: begin
                                r_state <= S_FAULT;
                                r_cause <= CAUSE_ILLEGAL;
                            end
                        endcase
                    end
                    S_MEM: begin
                        if (i_mem_ack) begin
                            r_state <= w_isLoad ? S_WB : S_FETCH;
                        end else if (w_expire) begin
                            r_state <= S_FAULT;
                            r_cause <= CAUSE_BUS_TIMEOUT;
                        end
                    end
                    S_WB, S_TRAP: r_state <= S_FETCH;
                    default:      r_state <= S_HALT;
                endcase
            end
        end
    end

    // Outputs are gated by rst_n so a reset mid-access drops mem_req without waiting for a clock.
    always_comb begin
        o_mem_req    = 1'b0;
        o_enBranch   = 1'b0;
        o_pcUpdate   = 1'b0;
        o_irWrite    = 1'b0;
        o_addrSrc    = ADDR_PC_OUT;
        o_memWrite   = 1'b0;
        o_memRead    = 1'b0;
        o_regSrc     = REG_PC;
        o_regWrite   = 1'b0;
        o_aluSrcA    = A_CURR_PC;
        o_aluSrcB    = B_RS2;
        o_aluCtrl    = ADD_OP;
        o_trap_taken = 1'b0;
        o_halted     = 1'b0;
        w_retire     = 1'b0;
        if (i_rst_n) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_req = 1'b1;
                    o_memRead = 1'b1;
                    o_addrSrc = ADDR_PC_OUT;
                end
                S_DECODE: begin
                    o_irWrite  = 1'b1;
                    o_pcUpdate = 1'b1;
                    o_aluSrcA  = A_CURR_PC;
                    o_aluSrcB  = B_FOUR;
                    o_aluCtrl  = ADD_OP;
                end
                S_EXECUTE: begin
                    // PC already holds PC+4 after DECODE, so link writes take REG_PC directly.
                    case (i_opcode)
                        OP_LUI: begin
                            o_regSrc = REG_ALU; o_regWrite = 1'b1;
                            o_aluSrcA = A_ZERO; o_aluSrcB = B_IMMED; w_retire = 1'b1;
                        end
                        OP_AUIPC: begin
                            o_regSrc = REG_ALU; o_regWrite = 1'b1;
                            o_aluSrcA = A_OLD_PC; o_aluSrcB = B_IMMED; w_retire = 1'b1;
                        end
                        OP_JAL: begin
                            o_regSrc = REG_PC; o_regWrite = 1'b1; o_pcUpdate = 1'b1;
                            o_aluSrcA = A_OLD_PC; o_aluSrcB = B_IMMED; w_retire = 1'b1;
                        end
                        OP_JALR: begin
                            o_regSrc = REG_PC; o_regWrite = 1'b1; o_pcUpdate = 1'b1;
                            o_aluSrcA = A_RS1; o_aluSrcB = B_IMMED; w_retire = 1'b1;
                        end
                        OP_BRANCH: begin
                            o_enBranch = 1'b1;
                            o_aluSrcA = A_OLD_PC; o_aluSrcB = B_IMMED; w_retire = 1'b1;
                        end
                        OP_OP: begin
                            o_regSrc = REG_ALU; o_regWrite = 1'b1; o_aluCtrl = ALU_OP;
                            o_aluSrcA = A_RS1; o_aluSrcB = B_RS2; w_retire = 1'b1;
                        end
                        OP_IMM: begin
                            o_regSrc = REG_ALU; o_regWrite = 1'b1; o_aluCtrl = ALU_OP;
                            o_aluSrcA = A_RS1; o_aluSrcB = B_IMMED; w_retire = 1'b1;
                        end
                        OP_LOAD, OP_STORE: begin
                            o_aluSrcA = A_RS1; o_aluSrcB = B_IMMED;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    o_mem_req  = 1'b1;
                    o_addrSrc  = ADDR_ALU_OUT;
                    o_memRead  = w_isLoad;
                    o_memWrite = !w_isLoad;
                    o_aluSrcA  = A_RS1;
                    o_aluSrcB  = B_IMMED;
                    w_retire   = i_mem_ack && !w_isLoad;
                end
                S_WB: begin
                    o_regSrc   = REG_MEM;
                    o_regWrite = 1'b1;
                    o_addrSrc  = ADDR_ALU_OUT;
                    w_retire   = 1'b1;
                end
                S_TRAP: begin
`ifdef CTRL_TRAP_EN
                    o_trap_taken = 1'b1;
                    o_pcUpdate   = 1'b1;
`endif
                end
                S_HALT:  o_halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_retire     = w_retire;
    assign o_trap_cause = r_cause;
    assign o_instret    = r_instret;

endmodule
